// File: rtl/led_frame_scheduler_if.sv
// Pixel RAM read port plus valid/ready pixel stream toward the LED encoder.
interface led_frame_scheduler_if #(
    parameter int unsigned IDX_BITS = 3
);
    logic                rd_en;
    logic [IDX_BITS-1:0] rd_addr;
    logic [23:0]         rd_data;
    logic [23:0]         pix_data;
    logic                pix_valid;
    logic                pix_ready;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Frame sequencer: fetches LENGTH pixels from a synchronous RAM, scales them by a
// per-frame brightness, hands them to the encoder over valid/ready, then idles the
// line for LATCH_CYCLES clocks before signalling frame completion.
module led_frame_scheduler #(
    parameter  int unsigned LENGTH       = 5,
    parameter  int unsigned LATCH_CYCLES = 2500,
    localparam int unsigned IDX_BITS     = $clog2(LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [7:0]            brightness,
    output logic                  sending_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [IDX_BITS-1:0]   cur_led,
    led_frame_scheduler_if.master bus
);

    // Counter only needs to hold LATCH_CYCLES-1; keep at least one bit.
    localparam int unsigned LAT_BITS = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LENGTH - 1);
    localparam logic [LAT_BITS-1:0] LAT_LOAD = LAT_BITS'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_LATCH
    } state_t;

    state_t              state, state_n;
    logic [IDX_BITS-1:0] idx, idx_n;
    logic [LAT_BITS-1:0] lat_cnt, lat_cnt_n;
    logic [7:0]          bri_q, bri_n;
    logic                done_n;

    // Each colour byte scaled as (c * (bri + 1)) >> 8, so 255 is identity.
    function automatic logic [23:0] scale(input logic [23:0] pix, input logic [7:0] bri);
        logic [15:0] prod;
        logic [23:0] res;
        res = '0;
        for (int b = 0; b < 3; b++) begin
            prod = 16'(pix[b*8 +: 8]) * (16'(bri) + 16'd1);
            res[b*8 +: 8] = 8'(prod >> 8);
        end
        return res;
    endfunction

    // Next-state, index, latch counter and brightness capture.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        lat_cnt_n = lat_cnt;
        bri_n     = bri_q;
        done_n    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    bri_n   = brightness;
                    idx_n   = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH:   state_n = S_WAIT;
            S_WAIT:    state_n = S_PRESENT;
            S_PRESENT: begin
                if (bus.pix_ready) begin
                    if (idx == LAST_IDX) begin
                        lat_cnt_n = LAT_LOAD;
                        state_n   = S_LATCH;
                    end else begin
                        idx_n   = idx + IDX_BITS'(1);
                        state_n = S_FETCH;
                    end
                end
            end
            S_LATCH: begin
                if (lat_cnt == '0) begin
                    if (continuous) begin
                        bri_n   = brightness;
                        idx_n   = '0;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    lat_cnt_n = lat_cnt - LAT_BITS'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Pulse lands on the final cycle spent in LATCH.
        if (state_n == S_LATCH && lat_cnt_n == '0) begin
            done_n = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            lat_cnt <= '0;
            bri_q   <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            lat_cnt <= lat_cnt_n;
            bri_q   <= bri_n;
        end
    end

    // Registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
            bus.pix_data  <= '0;
            bus.pix_valid <= 1'b0;
            sending_data  <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            cur_led       <= '0;
        end else begin
            bus.rd_en     <= (state_n == S_FETCH);
            bus.rd_addr   <= idx_n;
            bus.pix_valid <= (state_n == S_PRESENT);
            if (state == S_WAIT) begin
                bus.pix_data <= scale(bus.rd_data, bri_q);
            end
            sending_data  <= (state_n == S_FETCH) || (state_n == S_WAIT) ||
                             (state_n == S_PRESENT);
            busy          <= (state_n != S_IDLE);
            frame_done    <= done_n;
            cur_led       <= idx_n;
        end
    end

endmodule
